npu_job_ctrl: RTL
=================

# npu_job_ctrl

Matrix-job engine that sits directly downstream of the CPU's NPU launch outputs. On a rising edge of `en_npu` it latches the A/B/C matrix base addresses, reads A and B from shared data memory into local buffers, and computes C = A × B on signed 32-bit words. It then writes C back to memory and returns a one-cycle `acquire_npu` pulse, which the CPU consumes to release its matrix-instruction stall.

## Interface
Parameters:
- `DIM`, default 4: matrix dimension (DIM×DIM, row-major); power of two, 2..8.
- `AW`, default 10: memory word-address width; matches the CPU matrix address width.
- `DW`, default 32: data width.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `en_npu`  in  1  job request level from the CPU; a job starts on a 0→1 transition.
- `mat_a_addr`  in  AW  base word address of A.
- `mat_b_addr`  in  AW  base word address of B.
- `mat_c_addr`  in  AW  base word address of C.
- `acquire_npu`  out  1  one-cycle job-done pulse.
- `busy`  out  1  high from LOAD_A entry through DONE.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  AW  word address.
- `mem_wdata`  out  DW  write data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rdata`  in  DW  read data, valid exactly one cycle after a granted read.

## Operation
- States: IDLE → LOAD_A → LOAD_B → COMPUTE → STORE → DONE → IDLE.
- IDLE: a registered `en_prev` is kept. When `en_npu` = 1 and `en_prev` = 0, latch all three base addresses and enter LOAD_A. Address-input changes during a job are ignored.
- LOAD_A / LOAD_B:
  - Hold `mem_req` = 1, `mem_we` = 0, `mem_addr` = base + i, for i = 0..DIM²−1.
  - i advances only in cycles where `mem_gnt` = 1.
  - `mem_rdata` is written to buffer[i_granted] on the cycle after each grant.
  - After the last grant, one drain cycle follows with `mem_req` = 0 to capture the final word, then the next state is entered.
- COMPUTE: iterate r, c, k (k innermost), one MAC per cycle: acc += A[r][k]·B[k][c]. acc clears at k = 0 and is stored to C[r][c] at k = DIM−1. The product is signed 32×32; only the low 32 bits are kept, and addition wraps (unless the saturation build option is enabled).
- STORE: hold `mem_req` = 1, `mem_we` = 1, `mem_addr` = c_base + i, `mem_wdata` = C[i]; i advances on `mem_gnt`. After the last grant, enter DONE.
- DONE: `acquire_npu` = 1 for one cycle, then return to IDLE.
- Address arithmetic is modulo 2^AW (wraps past the top of memory).
- While `en_npu` stays high after DONE, no new job starts; it must go low and then high again.
- An `en_npu` edge arriving while busy is ignored; `en_prev` still tracks the input.

## Timing
- Reset values: `acquire_npu`, `busy`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0; state = IDLE; `en_prev` = 1. Because `en_prev` resets to 1, an `en_npu` held high through reset does not start a job.
- The start edge is sampled at cycle N; LOAD_A with `mem_req` high begins at N+1.
- With `mem_gnt` tied to 1:
  - LOAD_A: DIM²+1 cycles.
  - LOAD_B: DIM²+1 cycles.
  - COMPUTE: DIM³ cycles.
  - STORE: DIM² cycles.
  - DONE: 1 cycle.
  - For DIM = 4: `acquire_npu` is high at cycle N+115.
- Each cycle with `mem_gnt` = 0 stretches the current load or store phase by exactly one cycle; `mem_addr`, `mem_we`, and `mem_wdata` stay stable until granted.
- Reset asserted in any state: on the next edge, state = IDLE and `mem_req` = 0. No further writes occur and no `acquire_npu` is issued. Memory already written stays written.

## Configuration
- `NPU_SAT_EN` defined: each accumulate step saturates to 0x7FFFFFFF / 0x80000000 on signed overflow; the product is still truncated to its low 32 bits before the add.
- `NPU_SAT_EN` undefined: the accumulator wraps modulo 2^32.

## Test plan
- Identity: A = I at 0x000, B = 1..16 at 0x010, C base 0x020, `mem_gnt` = 1, rising edge at N → memory 0x020..0x02F = 1..16 and `acquire_npu` high only at N+115.
- Grant stalls: same data with `mem_gnt` at random 50% → identical C. Every address is held until granted, and no address is skipped or repeated.
- Wrap: `mat_c_addr` = 0x3FC → writes go to 0x3FC..0x3FF, then 0x000..0x00B.
- Saturation: A all 0x00010000, B all 0x00008000 (each product 0x80000000) → C = 0x80000000 with `NPU_SAT_EN`, 0x00000000 without.
- Reset mid-STORE: assert `rst` after 5 store grants while holding `en_npu` high → `mem_req` = 0 the next cycle, no `acquire_npu`, and no new job until `en_npu` goes 0 then 1.
- Re-trigger: `en_npu` held high across DONE → exactly one `acquire_npu`. Then drop `en_npu` for 1 cycle and raise it → a second full job runs.

Source files
------------

// File: rtl/npu_job_ctrl.sv
// Matrix-job engine: loads A and B from shared memory, computes C = A x B on signed words, stores C, pulses acquire_npu.
// Build option NPU_SAT_EN: saturating accumulation instead of modulo-2^DW wrap.
module npu_job_ctrl #(
  parameter int DIM = 4,
  parameter int AW  = 10,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_npu,
  input  logic [AW-1:0] mat_a_addr,
  input  logic [AW-1:0] mat_b_addr,
  input  logic [AW-1:0] mat_c_addr,
  output logic          acquire_npu,
  output logic          busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic [DW-1:0] mem_rdata
);

  localparam int NW = DIM * DIM;
  localparam int IW = $clog2(NW);
  localparam int KW = $clog2(DIM);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, STORE, DONE} state_t;

  state_t        state_reg, state_next;
  logic          en_prev_reg;
  logic [AW-1:0] a_base_reg, b_base_reg, c_base_reg;
  logic [IW-1:0] idx_reg;
  logic          drain_reg;
  logic          rd_valid_reg;
  logic [IW-1:0] rd_idx_reg;
  logic [KW-1:0] r_reg, c_reg, k_reg;
  logic [DW-1:0] acc_reg;

  logic [DW-1:0] a_buf [NW];
  logic [DW-1:0] b_buf [NW];
  logic [DW-1:0] c_buf [NW];

  logic          start;
  logic          last_idx;
  logic          k_last;
  logic          compute_last;
  logic [DW-1:0] prod;
  logic [DW-1:0] acc_in;
  logic [DW-1:0] raw_sum;
  logic [DW-1:0] mac_sum;

  assign start        = (state_reg == IDLE) && en_npu && !en_prev_reg;
  assign last_idx     = (idx_reg == IW'(NW - 1));
  assign k_last       = &k_reg;
  assign compute_last = k_last && (&c_reg) && (&r_reg);

  // Low DW bits of a product are the same for signed and unsigned operands,
  // so a DW-wide multiply gives the truncated signed product directly.
  assign prod    = a_buf[{r_reg, k_reg}] * b_buf[{k_reg, c_reg}];
  assign acc_in  = (k_reg == '0) ? '0 : acc_reg;
  assign raw_sum = acc_in + prod;

`ifdef NPU_SAT_EN
  logic ovf;
  assign ovf     = (acc_in[DW-1] == prod[DW-1]) && (raw_sum[DW-1] != acc_in[DW-1]);
  assign mac_sum = !ovf ? raw_sum :
                   acc_in[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
  assign mac_sum = raw_sum;
`endif

  always_comb begin
    state_next  = state_reg;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    acquire_npu = 1'b0;
    busy        = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD_A;
      end
      LOAD_A: begin
        if (drain_reg) begin
          state_next = LOAD_B;
        end else begin
          mem_req  = 1'b1;
          mem_addr = a_base_reg + AW'(idx_reg);
        end
      end
      LOAD_B: begin
        if (drain_reg) begin
          state_next = COMPUTE;
        end else begin
          mem_req  = 1'b1;
          mem_addr = b_base_reg + AW'(idx_reg);
        end
      end
      COMPUTE: begin
        if (compute_last) state_next = STORE;
      end
      STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = c_base_reg + AW'(idx_reg);
        mem_wdata = c_buf[idx_reg];
        if (mem_gnt && last_idx) state_next = DONE;
      end
      DONE: begin
        acquire_npu = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Index counters are exact powers of two, so they wrap back to zero at the end of each phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      en_prev_reg  <= 1'b1;
      a_base_reg   <= '0;
      b_base_reg   <= '0;
      c_base_reg   <= '0;
      idx_reg      <= '0;
      drain_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_idx_reg   <= '0;
      r_reg        <= '0;
      c_reg        <= '0;
      k_reg        <= '0;
      acc_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      en_prev_reg  <= en_npu;
      rd_valid_reg <= 1'b0;
      if (start) begin
        a_base_reg <= mat_a_addr;
        b_base_reg <= mat_b_addr;
        c_base_reg <= mat_c_addr;
        idx_reg    <= '0;
        drain_reg  <= 1'b0;
        r_reg      <= '0;
        c_reg      <= '0;
        k_reg      <= '0;
      end
      case (state_reg)
        LOAD_A, LOAD_B: begin
          if (drain_reg) begin
            drain_reg <= 1'b0;
          end else if (mem_gnt) begin
            rd_valid_reg <= 1'b1;
            rd_idx_reg   <= idx_reg;
            idx_reg      <= idx_reg + 1'b1;
            drain_reg    <= last_idx;
          end
        end
        COMPUTE: begin
          acc_reg <= mac_sum;
          k_reg   <= k_reg + 1'b1;
          if (k_last) c_reg <= c_reg + 1'b1;
          if (k_last && (&c_reg)) r_reg <= r_reg + 1'b1;
        end
        STORE: begin
          if (mem_gnt) idx_reg <= idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read data arrives the cycle after its grant, still inside the same load state.
  always_ff @(posedge clk) begin
    if (rd_valid_reg) begin
      if (state_reg == LOAD_A) a_buf[rd_idx_reg] <= mem_rdata;
      else                     b_buf[rd_idx_reg] <= mem_rdata;
    end
    if ((state_reg == COMPUTE) && k_last) c_buf[{r_reg, c_reg}] <= mac_sum;
  end

endmodule
